// File: rtl/osc_capture_buffer_pkg.sv
// Shared definitions for the oscilloscope capture path: geometry, capture
// state encoding, write-request struct and the sample-to-row mapping.
package osc_capture_buffer_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int Y_CENTER     = 240;
   localparam int TRIG_TIMEOUT = 4096;
   localparam int ADDR_W       = 10;
   localparam int TO_W         = $clog2(TRIG_TIMEOUT);

   typedef logic [9:0] row_t;

   typedef enum logic [1:0] {
      ST_ARM       = 2'd0,
      ST_WAIT_TRIG = 2'd1,
      ST_CAPTURE   = 2'd2,
      ST_FULL      = 2'd3
   } cap_state_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_req_t;

   // Row = Y_CENTER - 1.5*s; s = +127 lands on row 50, s = -128 on row 432.
   function automatic row_t sample_to_row(input logic [7:0] s);
      logic signed [10:0] sx;
      logic signed [10:0] y;
      sx = {{3{s[7]}}, s};
      y  = 11'(Y_CENTER) - sx - (sx >>> 1);
      return y[9:0];
   endfunction

endpackage

// File: rtl/osc_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// on contents so it maps onto block RAM.
module osc_dp_ram
   import osc_capture_buffer_pkg::*;
#(
   parameter int DEPTH = H_ACTIVE,
   parameter int AW    = ADDR_W,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/osc_capture_buffer.sv
// Triggered, double-buffered sweep capture feeding the VGA renderer; the
// back bank is filled after a level trigger and swapped in at vsync.
module osc_capture_buffer
   import osc_capture_buffer_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       KEY,
   input  logic [7:0] ifft_Isignal,
   input  logic [7:0] ifft_Qsignal,
   input  logic       iSample_en,
   input  logic       iSel,
   input  logic [7:0] iTrig_level,
   input  logic [3:0] iDecim,
   input  logic       iPix_en,
   input  logic       iBLANK_N,
   input  logic       iVS,
   output logic [9:0] oVal_CY,
   output logic [1:0] oState
);

   cap_state_t state, state_nxt;

   logic               sel_q;
   logic signed [7:0]  level_q;
   logic [3:0]         decim_q;
   logic [3:0]         dec_cnt;
   logic [ADDR_W-1:0]  waddr;
   logic [TO_W-1:0]    to_cnt;
   logic               have_prev;
   logic signed [7:0]  prev;
   logic               front_bank;
   logic               front_valid;
   logic               vs_q;
   wr_req_t            wr, wr_nxt;

   logic signed [7:0]  samp;
   logic               kept, trig, vs_fall, do_swap;

   assign samp    = sel_q ? signed'(ifft_Qsignal) : signed'(ifft_Isignal);
   assign kept    = iSample_en && (dec_cnt == decim_q);
   assign trig    = (have_prev && (prev < level_q) && (samp >= level_q)) ||
                    (to_cnt == TO_W'(TRIG_TIMEOUT - 1));
   assign vs_fall = vs_q && !iVS;
   assign oState  = state;

   always_comb begin
      state_nxt = state;
      wr_nxt    = '0;
      do_swap   = 1'b0;
      unique case (state)
         ST_ARM: state_nxt = ST_WAIT_TRIG;
         ST_WAIT_TRIG: begin
            if (kept && trig) begin
               wr_nxt.en   = 1'b1;
               wr_nxt.data = samp;
               state_nxt   = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (kept) begin
               wr_nxt.en   = 1'b1;
               wr_nxt.addr = waddr;
               wr_nxt.data = samp;
               if (waddr == ADDR_W'(H_ACTIVE - 1)) state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            // Only a FULL state sees the edge, so a final write coinciding
            // with vsync defers the swap to the next frame.
            if (vs_fall) begin
               do_swap   = 1'b1;
               state_nxt = ST_ARM;
            end
         end
         default: state_nxt = ST_ARM;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) state <= ST_ARM;
      else      state <= state_nxt;
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         sel_q       <= 1'b0;
         level_q     <= '0;
         decim_q     <= '0;
         dec_cnt     <= '0;
         waddr       <= '0;
         to_cnt      <= '0;
         have_prev   <= 1'b0;
         prev        <= '0;
         front_bank  <= 1'b0;
         front_valid <= 1'b0;
         vs_q        <= 1'b1;
         wr          <= '0;
      end else begin
         vs_q <= iVS;
         wr   <= wr_nxt;
         if (state == ST_ARM) begin
            sel_q     <= iSel;
            level_q   <= iTrig_level;
            decim_q   <= iDecim;
            dec_cnt   <= '0;
            waddr     <= '0;
            to_cnt    <= '0;
            have_prev <= 1'b0;
         end else if (iSample_en) begin
            dec_cnt <= (dec_cnt == decim_q) ? 4'd0 : dec_cnt + 4'd1;
         end
         if (state == ST_WAIT_TRIG && kept) begin
            if (trig) begin
               waddr <= ADDR_W'(1);
            end else begin
               prev      <= samp;
               have_prev <= 1'b1;
               to_cnt    <= to_cnt + 1'b1;
            end
         end
         if (state == ST_CAPTURE && kept) waddr <= waddr + 1'b1;
         if (do_swap) begin
            front_bank  <= ~front_bank;
            front_valid <= 1'b1;
         end
      end
   end

   // Display side: column counter -> RAM read -> registered row.
   logic [ADDR_W-1:0] x, raddr;
   logic [1:0][7:0]   rd;
   logic              disp_vld, disp_vld_q, rsel;

   assign raddr    = (x < ADDR_W'(H_ACTIVE)) ? x : '0;
   assign disp_vld = iBLANK_N && (x < ADDR_W'(H_ACTIVE)) && front_valid;

   // Writes are registered one cycle, so the bank is chosen from the
   // pre-swap front_bank even when the swap lands on the same edge.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      osc_dp_ram u_ram (
         .clk   (CLOCK_50),
         .we    (wr.en && (front_bank != 1'(b))),
         .waddr (wr.addr),
         .wdata (wr.data),
         .raddr (raddr),
         .rdata (rd[b])
      );
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         x          <= '0;
         disp_vld_q <= 1'b0;
         rsel       <= 1'b0;
         oVal_CY    <= row_t'(Y_CENTER);
      end else begin
         if (!iBLANK_N)
            x <= '0;
         else if (iPix_en && x != ADDR_W'(H_ACTIVE))
            x <= x + 1'b1;
         disp_vld_q <= disp_vld;
         rsel       <= front_bank;
         oVal_CY    <= disp_vld_q ? sample_to_row(rd[rsel]) : row_t'(Y_CENTER);
      end
   end

endmodule

// File: tb/tb_osc_capture_buffer.sv
// Directed + randomized bench for osc_capture_buffer against a sweep-level
// reference model (trigger search over kept samples, frame-level front bank).
module tb_osc_capture_buffer;

   localparam int TRIG_TO = 4096;
   localparam int NCOL    = 640;

   logic       CLOCK_50 = 1'b0;
   logic       KEY = 1'b0;
   logic [7:0] ifft_Isignal = '0, ifft_Qsignal = '0, iTrig_level = '0;
   logic       iSample_en = 1'b0, iSel = 1'b0, iPix_en = 1'b0, iBLANK_N = 1'b0, iVS = 1'b1;
   logic [3:0] iDecim = '0;
   logic [9:0] oVal_CY;
   logic [1:0] oState;

   osc_capture_buffer dut (
      .CLOCK_50     (CLOCK_50),
      .KEY          (KEY),
      .ifft_Isignal (ifft_Isignal),
      .ifft_Qsignal (ifft_Qsignal),
      .iSample_en   (iSample_en),
      .iSel         (iSel),
      .iTrig_level  (iTrig_level),
      .iDecim       (iDecim),
      .iPix_en      (iPix_en),
      .iBLANK_N     (iBLANK_N),
      .iVS          (iVS),
      .oVal_CY      (oVal_CY),
      .oState       (oState)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_cmp = 0, n_bad = 0;

   // reference model state
   int front_mem [NCOL];
   bit fv = 1'b0;
   int cfg_sel, cfg_level, cfg_decim;
   int nstrobe;
   bit triggered;
   int kq[$];
   int sweep[$];

   function automatic int sx8(input logic [7:0] v);
      return int'($signed(v));
   endfunction

   function automatic int yrow(input int s);
      int half;
      half = (s >= 0) ? s / 2 : -((1 - s) / 2);
      return 240 - s - half;
   endfunction

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic arm_cfg();
      cfg_sel   = int'(iSel);
      cfg_level = sx8(iTrig_level);
      cfg_decim = int'(iDecim);
   endtask

   task automatic feed(input int iv, input int qv, input bit vs_last, input string tag);
      int s;
      bit trg, last;
      repeat ($urandom_range(0, 2)) tick();
      ifft_Isignal = 8'(iv);
      ifft_Qsignal = 8'(qv);
      iSample_en   = 1'b1;
      nstrobe++;
      s   = cfg_sel != 0 ? sx8(8'(qv)) : sx8(8'(iv));
      trg = 1'b0;
      last = 1'b0;
      if (nstrobe % (cfg_decim + 1) == 0) begin
         if (!triggered) begin
            if ((kq.size() > 0 && kq[kq.size()-1] < cfg_level && s >= cfg_level) ||
                kq.size() == TRIG_TO - 1) begin
               triggered = 1'b1;
               trg = 1'b1;
               sweep.push_back(s);
            end else begin
               kq.push_back(s);
            end
         end else if (sweep.size() < NCOL) begin
            sweep.push_back(s);
            last = (sweep.size() == NCOL);
         end
      end
      if (last && vs_last) iVS = 1'b0;
      tick();
      iSample_en = 1'b0;
      if (trg)  check({tag, "_trig_lat"}, 32'(oState), 32'd2);
      if (last) check({tag, "_full_lat"}, 32'(oState), 32'd3);
   endtask

   // mode 0: ramp from -128 wrapping, 1: constant -50, 2: random
   task automatic run_capture(input int mode, input bit vs_last, input int stop_at, input string tag);
      int v, iv;
      v = -128;
      nstrobe = 0;
      triggered = 1'b0;
      kq.delete();
      sweep.delete();
      check({tag, "_armed"}, 32'(oState), 32'd1);
      for (int n = 0; n < 20000 && sweep.size() < NCOL; n++) begin
         case (mode)
            0:       begin iv = v; v = (v == 127) ? -128 : v + 1; end
            1:       iv = -50;
            default: iv = int'($urandom_range(0, 255)) - 128;
         endcase
         feed(iv, int'($urandom_range(0, 255)) - 128, vs_last, tag);
         if (stop_at >= 0 && sweep.size() >= stop_at) return;
      end
      check({tag, "_sweep_len"}, 32'(sweep.size()), 32'(NCOL));
   endtask

   task automatic vs_pulse(input bit swap);
      iVS = 1'b0;
      tick();
      if (swap) begin
         for (int i = 0; i < NCOL; i++) front_mem[i] = sweep[i];
         fv = 1'b1;
         arm_cfg();
      end
      tick();
      tick();
      iVS = 1'b1;
      tick();
      tick();
   endtask

   // One video line: blank, then 680 pixel strobes at half rate, then blank.
   task automatic scan(input string tag);
      int xp, x2, b1, xn, b, p, e;
      iBLANK_N = 1'b0;
      iPix_en  = 1'b0;
      repeat (4) tick();
      xp = 0; x2 = 0; b1 = 0;
      for (int c = 0; c < 1400; c++) begin
         b = (c < 1360) ? 1 : 0;
         p = (c % 2 == 0) ? 1 : 0;
         iBLANK_N = b[0];
         iPix_en  = p[0];
         tick();
         xn = (b == 0) ? 0 : ((p == 1 && xp < NCOL) ? xp + 1 : xp);
         e  = (b1 == 1 && x2 < NCOL && fv) ? yrow(front_mem[x2]) : 240;
         check(tag, 32'(oVal_CY), 32'(e));
         x2 = xp; b1 = b; xp = xn;
      end
      iBLANK_N = 1'b0;
      iPix_en  = 1'b0;
      tick();
   endtask

   initial begin
      // power-on reset
      repeat (3) tick();
      check("rst_state", 32'(oState), 32'd0);
      check("rst_val", 32'(oVal_CY), 32'd240);
      KEY = 1'b1;
      arm_cfg();
      tick(); tick();
      scan("boot");

      // ramp, level 0: trigger on sample 0
      run_capture(0, 1'b0, -1, "ramp");
      iTrig_level = 8'd10;
      vs_pulse(1'b1);
      scan("ramp");

      // constant below level: forced trigger after timeout
      run_capture(1, 1'b0, -1, "const");
      iTrig_level = 8'd0;
      iDecim = 4'd3;
      vs_pulse(1'b1);
      scan("const");

      // decimated ramp; sweep finishes mid-frame, old data persists
      run_capture(0, 1'b0, -1, "decim");
      scan("midframe");
      iSel = 1'b1;
      iTrig_level = 8'($urandom_range(0, 120) - 60);
      iDecim = 4'($urandom_range(0, 2));
      vs_pulse(1'b1);
      iTrig_level = 8'($urandom_range(0, 255));
      scan("decim");

      // random Q capture; vsync outside FULL ignored; final write on vsync edge
      vs_pulse(1'b0);
      check("vs_wait_state", 32'(oState), 32'd1);
      run_capture(2, 1'b1, -1, "coinc");
      repeat (3) tick();
      check("coinc_noswap", 32'(oState), 32'd3);
      iVS = 1'b1;
      scan("coinc_old");
      iSel = 1'b0;
      iTrig_level = 8'd0;
      iDecim = 4'd0;
      vs_pulse(1'b1);
      scan("coinc_new");

      // reset mid-capture at address 300
      run_capture(0, 1'b0, 300, "abort");
      check("abort_state_pre", 32'(oState), 32'd2);
      KEY = 1'b0;
      #2;
      check("abort_state", 32'(oState), 32'd0);
      check("abort_val", 32'(oVal_CY), 32'd240);
      fv = 1'b0;
      tick(); tick();
      iTrig_level = 8'($urandom_range(0, 80) - 40);
      KEY = 1'b1;
      arm_cfg();
      tick(); tick();
      scan("abort_cols");
      run_capture(2, 1'b0, -1, "rerun");
      scan("rerun_old");
      vs_pulse(1'b1);
      scan("rerun_new");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/osc_capture_buffer.md
# osc_capture_buffer

Triggered, double-buffered waveform capture stage that feeds the oscilloscope VGA renderer. It runs in the CLOCK_50 domain and takes the 8-bit signed IFFT I/Q streams. It captures one 640-sample sweep of the selected channel after a level trigger, then converts each stored sample to a screen row. During active video it presents the row for the current column as oVal_CY. Banks swap only at vertical sync, so a frame never shows a half-written sweep.

## Interface
- H_ACTIVE, 640: samples per sweep, equal to visible columns
- Y_CENTER, 240: row for sample value 0
- TRIG_TIMEOUT, 4096: decimated samples to wait in WAIT_TRIG before forcing a trigger
- ADDR_W, 10: buffer address width
- CLOCK_50  in  1  system clock; all logic on its rising edge
- KEY  in  1  asynchronous active-low reset
- ifft_Isignal  in  8  I sample, two's complement
- ifft_Qsignal  in  8  Q sample, two's complement
- iSample_en  in  1  one-cycle strobe: both sample inputs are valid this cycle
- iSel  in  1  channel select: 0 = I, 1 = Q
- iTrig_level  in  8  signed trigger level
- iDecim  in  4  keep every (iDecim+1)-th strobed sample
- iPix_en  in  1  pixel strobe, one cycle per VGA pixel
- iBLANK_N  in  1  high during active video
- iVS  in  1  vertical sync, active low
- oVal_CY  out  10  row to draw for the current column
- oState  out  2  capture state: 0 ARM, 1 WAIT_TRIG, 2 CAPTURE, 3 FULL

## Operation
- Storage: two banks of H_ACTIVE x 8 bits. The capture side writes the back bank and the display side reads the front bank. Memory contents are not reset.
- ARM lasts one cycle.
  - Latches iSel, iTrig_level and iDecim. Changes to these are ignored until the next ARM.
  - Clears the decimation counter, the write address, the timeout counter and the have_prev flag.
  - Next state is WAIT_TRIG.
- Decimation: a strobed sample counts as "kept" when the decimation counter equals the latched iDecim. The counter then returns to 0; otherwise it increments.
- WAIT_TRIG, on each kept sample s:
  - The trigger fires when have_prev=1, prev < level and s >= level (signed compare).
  - The trigger also fires when the timeout counter reaches TRIG_TIMEOUT-1.
  - On a trigger: write s to back[0], set the write address to 1, go to CAPTURE.
  - Otherwise: prev <= s, have_prev <= 1, increment the timeout counter.
- CAPTURE, on each kept sample: write it to back[addr], then addr++. The write to addr = H_ACTIVE-1 moves the state to FULL.
- FULL: kept samples are discarded. On a falling edge of iVS (registered previous value 1, current 0):
  - swap front/back
  - set front_valid <= 1
  - go to ARM
- An iVS falling edge in any state other than FULL does nothing. If the final CAPTURE write and the iVS edge fall in the same cycle, there is no swap; the swap waits for the next frame.
- Display column counter X:
  - cleared while iBLANK_N=0
  - increments on iPix_en while iBLANK_N=1
  - saturates at H_ACTIVE
- Row mapping from sample s: Y = Y_CENTER - s - (s>>>1), in 11-bit signed arithmetic, truncated to 10 bits. Range is 50 (s=127) to 432 (s=-128).
- oVal_CY = Y(front[X]) when front_valid=1 and X < H_ACTIVE; otherwise Y_CENTER.

## Timing
- Reset values:
  - state ARM, oState=0
  - oVal_CY=240
  - front bank 0, front_valid=0
  - all counters 0, iVS history register 1
- Reset asserted mid-capture aborts the sweep immediately. front_valid clears.
- Trigger latency: the triggering sample is written in the cycle after its iSample_en strobe, and oState=2 in that same cycle.
- Display latency:
  - iPix_en at column X, cycle t: X updates at t+1.
  - Synchronous RAM read at t+2.
  - oVal_CY registered at t+3.
  - The value holds until the next update.
- The read port never stalls and is independent of the capture state.
- The swap is a single cycle. Reads from the new front bank begin the next cycle. This is always inside vertical blanking.

## Structure
- A shared package holds:
  - the state encoding
  - H_ACTIVE, Y_CENTER and the 10-bit row type
  - the row-mapping function, reused by the renderer's guide-line logic
- One sub-module, osc_dp_ram: simple dual-port 8-bit RAM with one write port and a registered read port, instantiated twice. This maps to M9K blocks.
- The state machine, trigger compare and display counter stay in the top module.

## Test plan
- Ramp I from -128 to +127, step 1 every strobe; iSel=0, level=0, iDecim=0:
  - trigger fires on sample 0
  - back[0..127] = 0..127, then the ramp wraps
  - after the iVS edge, column 0 reads row 240 and column 100 reads row 90
- Constant I=-50, level=10: no crossing occurs. A forced trigger fires after 4096 kept samples; all 640 columns read row 315.
- iDecim=3 with a ramp: stored samples are every 4th input. The capture takes 2560 strobes.
- Sweep completes mid-frame: there is no swap until the iVS falling edge, and oVal_CY stays at the old data all frame. The final write coinciding with the iVS edge swaps one frame later.
- KEY asserted during CAPTURE at addr=300:
  - oState=0, oVal_CY=240 for all columns until the next full sweep and swap
- Columns 640 and above, and blanking: oVal_CY=240. X restarts at 0 on the next line.
